// File: rtl/bsk_prd_poller.sv
// bsk_prd_poller: strobe-bus master that polls one BskPRD command receiver,
// validates and publishes its decoded command word, and writes back indication/test-enable.
module bsk_prd_poller #(
  parameter logic [3:0] CS       = 4'b1011,
  parameter logic [7:0] PASSWORD = 8'hA4,
  parameter int unsigned T_STB   = 2
) (
  input  logic        clk,
  input  logic        iRes,
  input  logic        iPoll,
  input  logic        iIndEn,
  input  logic        iTestEn,
  input  logic [15:0] iD,
  output logic [15:0] oD,
  output logic        oDOe,
  output logic [3:0]  oCS,
  output logic [1:0]  oA,
  output logic        oRd,
  output logic        oWr,
  output logic        oBusy,
  output logic [15:0] oCom,
  output logic        oComValid,
  output logic        oErr,
  output logic [7:0]  oErrCnt,
  output logic        oNoDev
);
  typedef enum logic [2:0] {IDLE, RD_ID, RD_LO, RD_HI, WR_IND, WR_CTL, DONE} state_t;
  typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;
  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [3:0]  cnt, cnt_n;
  logic        rd, wr, last_stb, pwd_ok, tst, dec_ok;
  logic [15:0] lo, hi, dec;
  function automatic logic byte_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction
  assign last_stb = phase == STROBE && cnt == 4'(T_STB - 1);
  assign dec_ok   = byte_ok(lo[15:8]) && byte_ok(lo[7:0]) && byte_ok(hi[15:8]) && byte_ok(hi[7:0]);
  assign dec      = {hi[11:8], hi[3:0], lo[11:8], lo[3:0]};
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      state <= IDLE;
      phase <= SETUP;
      cnt   <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cnt   <= cnt_n;
    end
  end
  // every access state runs SETUP -> T_STB x STROBE -> HOLD, then advances
  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    if (state == IDLE) begin
      phase_n = SETUP;
      if (iPoll) state_n = RD_ID;
    end else if (state == DONE) begin
      phase_n = SETUP;
      state_n = IDLE;
    end else if (phase == SETUP) begin
      phase_n = STROBE;
      cnt_n   = '0;
    end else if (phase == STROBE) begin
      phase_n = last_stb ? HOLD : STROBE;
      cnt_n   = cnt + 4'd1;
    end else begin
      phase_n = SETUP;
      case (state)
        RD_ID:   state_n = pwd_ok ? RD_LO : DONE;
        RD_LO:   state_n = RD_HI;
        RD_HI:   state_n = (dec_ok && iIndEn) ? WR_IND : WR_CTL;
        WR_IND:  state_n = WR_CTL;
        default: state_n = DONE;
      endcase
    end
  end
  always_comb begin
    rd    = state == RD_ID || state == RD_LO || state == RD_HI;
    wr    = state == WR_IND || state == WR_CTL;
    oBusy = state != IDLE;
    oCS   = (rd || wr) ? CS : ~CS;
    oA    = state == RD_HI ? 2'd1 : state == WR_IND ? 2'd2 :
            (state == RD_ID || state == WR_CTL) ? 2'd3 : 2'd0;
    oRd   = !(rd && phase == STROBE);
    oWr   = !(wr && phase == STROBE);
    oDOe  = wr;
    oD    = state == WR_IND ? oCom :
            state == WR_CTL ? {15'b0, phase == SETUP ? iTestEn : tst} : 16'h0;
  end
  // read data lands on the edge closing the last strobe cycle; decisions are taken at the end of HOLD
  always_ff @(posedge clk or negedge iRes) begin
    if (!iRes) begin
      pwd_ok    <= 1'b0;
      tst       <= 1'b0;
      lo        <= '0;
      hi        <= '0;
      oCom      <= '0;
      oComValid <= 1'b0;
      oErr      <= 1'b0;
      oErrCnt   <= '0;
      oNoDev    <= 1'b0;
    end else begin
      oComValid <= 1'b0;
      oErr      <= 1'b0;
      if (state == RD_ID && last_stb) pwd_ok <= iD[15:8] == PASSWORD;
      if (state == RD_LO && last_stb) lo <= iD;
      if (state == RD_HI && last_stb) hi <= iD;
      if (state == WR_CTL && phase == SETUP) tst <= iTestEn;
      if (state == RD_ID && phase == HOLD) begin
        oNoDev <= !pwd_ok;
        oErr   <= !pwd_ok;
      end
      if (state == RD_HI && phase == HOLD) begin
        if (dec_ok) begin
          oCom      <= dec;
          oComValid <= 1'b1;
        end else begin
          oErr    <= 1'b1;
          oErrCnt <= oErrCnt == 8'hFF ? oErrCnt : oErrCnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bsk_prd_poller.sv
// tb_bsk_prd_poller: directed polls against a transaction-level model of the PRD bus master.
module tb_bsk_prd_poller;
  localparam logic [3:0] CS = 4'b1011;
  localparam int T_STB = 2;
  typedef struct packed {logic w; logic [1:0] a; logic [15:0] d; logic [7:0] len;} acc_t;
  logic clk = 0, iRes = 0, iPoll = 0, iIndEn = 0, iTestEn = 0;
  logic [15:0] iD, oD, oCom;
  logic oDOe, oRd, oWr, oBusy, oComValid, oErr, oNoDev;
  logic [3:0] oCS;
  logic [1:0] oA;
  logic [7:0] oErrCnt;
  logic [15:0] regs [4];
  int checks = 0, errors = 0;
  acc_t mq[$], eq[$];
  int busy_n, cv_n, err_n;
  logic in_stb = 0, pw, settled = 0, m_nodev = 0;
  logic [1:0] pa;
  logic [15:0] pd, m_com = 0;
  logic [3:0] pcs;
  logic [7:0] plen, m_cnt = 0;

  always #5 clk = ~clk;
  assign iD = regs[oA];

  bsk_prd_poller #(.CS(CS), .PASSWORD(8'hA4), .T_STB(T_STB)) dut (
    .clk(clk), .iRes(iRes), .iPoll(iPoll), .iIndEn(iIndEn), .iTestEn(iTestEn),
    .iD(iD), .oD(oD), .oDOe(oDOe), .oCS(oCS), .oA(oA), .oRd(oRd), .oWr(oWr),
    .oBusy(oBusy), .oCom(oCom), .oComValid(oComValid), .oErr(oErr),
    .oErrCnt(oErrCnt), .oNoDev(oNoDev));

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic byte_good(input logic [7:0] b);
    return (b[7:4] ^ b[3:0]) == 4'hF;
  endfunction

  // bus monitor: protocol checks every cycle, reassembles strobes into accesses
  always @(negedge clk) begin
    if (!iRes) begin
      in_stb = 0;
      mq.delete();
    end else begin
      chk("one_strobe", {oRd, oWr} == 2'b00, 0);
      if (!oRd || !oWr) begin
        chk("cs_in_strobe", oCS, CS);
        if (!oWr) chk("oe_in_write", oDOe, 1);
        if (in_stb) begin
          chk("bus_stable", {oA, oD, oCS, oWr}, {pa, pd, pcs, !pw});
          plen++;
        end else plen = 1;
        pa = oA; pd = oD; pcs = oCS; pw = !oWr;
        in_stb = 1;
      end else if (in_stb) begin
        mq.push_back({pw, pa, pw ? pd : 16'h0, plen});
        in_stb = 0;
      end
      if (oBusy) busy_n++;
      if (oComValid) cv_n++;
      if (oErr) err_n++;
      if (settled && !oBusy)
        chk("idle_outputs", {oCom, oErrCnt, oNoDev, oComValid, oErr, oDOe, oCS, oRd, oWr},
            {m_com, m_cnt, m_nodev, 3'b000, ~CS, 2'b11});
    end
  end

  task automatic do_poll(input logic [15:0] a3, input logic [15:0] a0, input logic [15:0] a1,
                         input logic ind, input logic ten, input logic spam);
    logic pwd, good;
    logic [15:0] com;
    int n;
    @(negedge clk);
    settled = 0;
    regs[3] = a3; regs[0] = a0; regs[1] = a1; regs[2] = 16'hDEAD;
    iIndEn = ind; iTestEn = ten;
    mq.delete(); eq.delete();
    busy_n = 0; cv_n = 0; err_n = 0;
    pwd  = a3[15:8] == 8'hA4;
    good = byte_good(a0[15:8]) & byte_good(a0[7:0]) & byte_good(a1[15:8]) & byte_good(a1[7:0]);
    com  = {a1[11:8], a1[3:0], a0[11:8], a0[3:0]};
    eq.push_back({1'b0, 2'd3, 16'h0, 8'(T_STB)});
    if (pwd) begin
      eq.push_back({1'b0, 2'd0, 16'h0, 8'(T_STB)});
      eq.push_back({1'b0, 2'd1, 16'h0, 8'(T_STB)});
      if (good && ind) eq.push_back({1'b1, 2'd2, com, 8'(T_STB)});
      eq.push_back({1'b1, 2'd3, {15'b0, ten}, 8'(T_STB)});
    end
    iPoll = 1;
    @(negedge clk);
    if (!spam) iPoll = 0;
    n = 0;
    while (oBusy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    iPoll = 0;
    chk("poll_timeout", n < 200, 1);
    chk("busy_cycles", busy_n, eq.size() * (T_STB + 2) + 1);
    chk("access_count", mq.size(), eq.size());
    foreach (eq[i]) if (i < mq.size()) chk("access", mq[i], eq[i]);
    chk("com_valid_pulses", cv_n, pwd && good);
    chk("err_pulses", err_n, !(pwd && good));
    if (!pwd) m_nodev = 1;
    else begin
      m_nodev = 0;
      if (good) m_com = com;
      else m_cnt = m_cnt == 8'hFF ? m_cnt : m_cnt + 8'd1;
    end
    settled = 1;
    repeat (3) @(negedge clk);
    chk("idle_busy", oBusy, 0);
  endtask

  initial begin
    int n;
    regs[0] = 0; regs[1] = 0; regs[2] = 0; regs[3] = 0;
    repeat (2) @(negedge clk);
    chk("rst_cs", oCS, 4'b0100);
    chk("rst_strobes", {oRd, oWr, oDOe, oBusy}, 4'b1100);
    chk("rst_regs", {oD, oCom, oComValid, oErr, oErrCnt, oNoDev}, 0);
    iRes = 1;
    settled = 1;
    do_poll(16'hA44A, 16'hC3E1, 16'hE1C3, 1, 1, 0);
    chk("t1_com", oCom, 16'h1331);
    chk("t1_accesses", mq.size(), 5);
    do_poll(16'hA44A, 16'hF0F0, 16'h0F0F, 0, 0, 0);
    chk("t2_com", oCom, 16'hFF00);
    chk("t2_accesses", mq.size(), 4);
    do_poll(16'hA44A, 16'hF0F0, 16'hE1C2, 1, 1, 0);
    chk("t3_errcnt", oErrCnt, 8'd1);
    chk("t3_com_held", oCom, 16'hFF00);
    for (int k = 0; k < 300; k++) do_poll(16'hA44A, 16'hC3E1, 16'hE1C2, 1, k[0], 0);
    chk("t3_errcnt_sat", oErrCnt, 8'hFF);
    do_poll(16'h5500, 16'hC3E1, 16'hE1C3, 1, 1, 0);
    chk("t4_nodev", oNoDev, 1);
    chk("t4_accesses", mq.size(), 1);
    do_poll(16'hA44A, 16'hC3E1, 16'hE1C3, 1, 0, 0);
    chk("t4_nodev_clr", oNoDev, 0);
    do_poll(16'hA44A, 16'hF0F0, 16'h0F0F, 1, 1, 1);
    chk("t5_accesses", mq.size(), 5);
    @(negedge clk);
    settled = 0;
    regs[3] = 16'hA44A; regs[0] = 16'hC3E1; regs[1] = 16'hE1C3;
    iPoll = 1;
    @(negedge clk);
    iPoll = 0;
    n = 0;
    while (!(oA == 2'd1 && oRd == 1'b0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_rd_hi", n < 100, 1);
    #1 iRes = 0;
    #1;
    chk("t6_rd", oRd, 1);
    chk("t6_cs", oCS, 4'b0100);
    chk("t6_busy", oBusy, 0);
    chk("t6_errcnt", oErrCnt, 0);
    m_com = 0; m_cnt = 0; m_nodev = 0;
    repeat (2) @(negedge clk);
    iRes = 1;
    settled = 1;
    do_poll(16'hA44A, 16'hC3E1, 16'hE1C3, 1, 1, 0);
    chk("t6_com", oCom, 16'h1331);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
